// File: rtl/regfile_mp_pkg.sv
// Shared raisin64 CPU constants used to size the multi-ported register file.
package regfile_mp_pkg;
    localparam int RF_DATA_W = 64;
    localparam int RF_ADDR_W = 6;
    localparam int RF_NREAD  = 3;
    localparam int RF_NWRITE = 2;
endpackage

// File: rtl/regfile_wsel.sv
// Per-read-port write resolve and bypass: yields the data and busy state a read
// must see after the current edge (write-first, issue beats write, r0 forced clean).
module regfile_wsel
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NWRITE = RF_NWRITE
) (
    input  logic [ADDR_W-1:0]        rd_rn,
    input  logic [DATA_W-1:0]        rf_data,
    input  logic                     rf_busy,
    input  logic [NWRITE-1:0]        w_en,
    input  logic [NWRITE*ADDR_W-1:0] w_rn,
    input  logic [NWRITE*DATA_W-1:0] w_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_rn,
    output logic [DATA_W-1:0]        byp_data,
    output logic                     byp_busy
);
    always_comb begin
        byp_data = rf_data;
        byp_busy = rf_busy;
        // Ascending scan so the highest-numbered matching write port wins.
        for (int j = 0; j < NWRITE; j++) begin
            if (w_en[j] && (w_rn[j*ADDR_W +: ADDR_W] == rd_rn)) begin
                byp_data = w_data[j*DATA_W +: DATA_W];
                byp_busy = 1'b0;
            end
        end
        if (iss_en && (iss_rn == rd_rn)) byp_busy = 1'b1;
        if (rd_rn == '0) begin
            byp_data = '0;
            byp_busy = 1'b0;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with busy scoreboard, registered write-first read ports.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREAD  = RF_NREAD,
    parameter int NWRITE = RF_NWRITE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREAD-1:0]         r_en,
    input  logic [NREAD*ADDR_W-1:0]  r_rn,
    output logic [NREAD*DATA_W-1:0]  r_data,
    output logic [NREAD-1:0]         r_busy,
    input  logic [NWRITE-1:0]        w_en,
    input  logic [NWRITE*ADDR_W-1:0] w_rn,
    input  logic [NWRITE*DATA_W-1:0] w_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_rn,
    output logic [2**ADDR_W-1:0]     busy_vec
);
    localparam int DEPTH = 2**ADDR_W;

    if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
        $error("regfile_mp: NREAD must be 1..4");
    end
    if (NWRITE < 1 || NWRITE > 2) begin : g_bad_nwrite
        $error("regfile_mp: NWRITE must be 1..2");
    end
    if (DATA_W < 1 || ADDR_W < 1) begin : g_bad_width
        $error("regfile_mp: DATA_W and ADDR_W must be positive");
    end

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [NREAD-1:0][DATA_W-1:0] r_data_q, r_data_d, byp_data;
    logic [NREAD-1:0]             r_busy_q, r_busy_d, byp_busy;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int j = 0; j < NWRITE; j++) begin
            if (w_en[j]) begin
                regs_d[w_rn[j*ADDR_W +: ADDR_W]] = w_data[j*DATA_W +: DATA_W];
                busy_d[w_rn[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_en) busy_d[iss_rn] = 1'b1;
        // r0 is hardwired: any write or issue aimed at it is dropped here.
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        regfile_wsel #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W),
            .NWRITE(NWRITE)
        ) u_wsel (
            .rd_rn   (r_rn[k*ADDR_W +: ADDR_W]),
            .rf_data (regs_q[r_rn[k*ADDR_W +: ADDR_W]]),
            .rf_busy (busy_q[r_rn[k*ADDR_W +: ADDR_W]]),
            .w_en    (w_en),
            .w_rn    (w_rn),
            .w_data  (w_data),
            .iss_en  (iss_en),
            .iss_rn  (iss_rn),
            .byp_data(byp_data[k]),
            .byp_busy(byp_busy[k])
        );
    end

    always_comb begin
        r_data_d = r_data_q;
        r_busy_d = r_busy_q;
        for (int k = 0; k < NREAD; k++) begin
            if (r_en[k]) begin
                r_data_d[k] = byp_data[k];
                r_busy_d[k] = byp_busy[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q   <= '0;
            busy_q   <= '0;
            r_data_q <= '0;
            r_busy_q <= '0;
        end else begin
            regs_q   <= regs_d;
            busy_q   <= busy_d;
            r_data_q <= r_data_d;
            r_busy_q <= r_busy_d;
        end
    end

    assign r_data   = r_data_q;
    assign r_busy   = r_busy_q;
    assign busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: read expectations are queued when driven and
// compared one cycle later; directed scenarios plus a small-model random run.
module tb_regfile_mp;
    localparam int DW = 64;
    localparam int AW = 6;
    localparam int NR = 3;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NR-1:0]     r_en;
    logic [NR*AW-1:0]  r_rn;
    logic [NR*DW-1:0]  r_data;
    logic [NR-1:0]     r_busy;
    logic [NW-1:0]     w_en;
    logic [NW*AW-1:0]  w_rn;
    logic [NW*DW-1:0]  w_data;
    logic              iss_en;
    logic [AW-1:0]     iss_rn;
    logic [2**AW-1:0]  busy_vec;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .NWRITE(NW)) dut (
        .clk(clk), .rst_n(rst_n), .r_en(r_en), .r_rn(r_rn), .r_data(r_data),
        .r_busy(r_busy), .w_en(w_en), .w_rn(w_rn), .w_data(w_data),
        .iss_en(iss_en), .iss_rn(iss_rn), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [DW-1:0] data;
        logic        busy;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic idle();
        r_en = '0; r_rn = '0; w_en = '0; w_rn = '0; w_data = '0;
        iss_en = 1'b0; iss_rn = '0;
    endtask

    task automatic rd(input int k, input int rn, input logic [DW-1:0] d,
                      input logic b, input string nm);
        exp_t e;
        r_en[k] = 1'b1;
        r_rn[k*AW +: AW] = AW'(rn);
        e.port = k; e.data = d; e.busy = b; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wr(input int j, input int rn, input logic [DW-1:0] d);
        w_en[j] = 1'b1;
        w_rn[j*AW +: AW] = AW'(rn);
        w_data[j*DW +: DW] = d;
    endtask

    task automatic iss(input int rn);
        iss_en = 1'b1;
        iss_rn = AW'(rn);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (busy_vec !== '0 || r_data !== '0 || r_busy !== '0)
            $display("FAIL reset_state: busy_vec=%h r_busy=%b r_data=%h required all zero",
                     busy_vec, r_busy, r_data);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        for (int rn = 1; rn < 64; rn += 3) begin
            idle();
            for (int k = 0; k < NR; k++) rd(k, rn + k, '0, 1'b0, "reset_read");
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_total++;
                if (r_data[e.port*DW +: DW] !== e.data || r_busy[e.port] !== e.busy)
                    $display("FAIL %s port%0d: got %h/%b required %h/%b", e.name, e.port,
                             r_data[e.port*DW +: DW], r_busy[e.port], e.data, e.busy);
                else n_pass++;
            end
        end
        n_total++;
        if (busy_vec !== '0) $display("FAIL reset_busy_vec: got %h required 0", busy_vec);
        else n_pass++;
    endtask

    task automatic test_write_read();
        exp_t e;
        idle(); wr(0, 5, 64'hDEAD_BEEF); tick();
        idle(); rd(2, 5, 64'hDEAD_BEEF, 1'b0, "write_then_read"); tick();
        idle();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_total++;
            if (r_data[e.port*DW +: DW] !== e.data || r_busy[e.port] !== e.busy)
                $display("FAIL %s port%0d: got %h/%b required %h/%b", e.name, e.port,
                         r_data[e.port*DW +: DW], r_busy[e.port], e.data, e.busy);
            else n_pass++;
        end
        wr(1, 5, 64'h1234); tick();
        n_total++;
        if (r_data[2*DW +: DW] !== 64'hDEAD_BEEF)
            $display("FAIL read_hold: got %h required %h", r_data[2*DW +: DW], 64'hDEAD_BEEF);
        else n_pass++;
    endtask

    task automatic test_same_reg_write();
        exp_t e;
        idle(); wr(0, 7, 64'h11); wr(1, 7, 64'h22);
        rd(0, 7, 64'h22, 1'b0, "dual_write_bypass"); tick();
        idle(); rd(1, 7, 64'h22, 1'b0, "dual_write_stored");
        rd(2, 7, 64'h22, 1'b0, "dual_write_stored"); tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_total++;
            if (r_data[e.port*DW +: DW] !== e.data || r_busy[e.port] !== e.busy)
                $display("FAIL %s port%0d: got %h/%b required %h/%b", e.name, e.port,
                         r_data[e.port*DW +: DW], r_busy[e.port], e.data, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_issue_write();
        exp_t e;
        idle(); iss(9); tick();
        n_total++;
        if (busy_vec[9] !== 1'b1) $display("FAIL issue_sets_busy: got %b required 1", busy_vec[9]);
        else n_pass++;
        idle(); iss(9); wr(0, 9, 64'h5); rd(0, 9, 64'h5, 1'b1, "issue_beats_write"); tick();
        n_total++;
        if (busy_vec[9] !== 1'b1) $display("FAIL issue_beats_write_vec: got %b required 1", busy_vec[9]);
        else n_pass++;
        idle(); rd(1, 9, 64'h5, 1'b1, "busy_data_stored"); tick();
        idle(); wr(1, 9, 64'h6); rd(2, 9, 64'h6, 1'b0, "write_clears_busy"); tick();
        n_total++;
        if (busy_vec[9] !== 1'b0) $display("FAIL write_clears_vec: got %b required 0", busy_vec[9]);
        else n_pass++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_total++;
            if (e.port == 2 && (r_data[e.port*DW +: DW] !== e.data || r_busy[e.port] !== e.busy))
                $display("FAIL %s port%0d: got %h/%b required %h/%b", e.name, e.port,
                         r_data[e.port*DW +: DW], r_busy[e.port], e.data, e.busy);
            else if (e.port != 2 && r_data[e.port*DW +: DW] !== e.data)
                $display("FAIL %s port%0d: got %h required %h (held)", e.name, e.port,
                         r_data[e.port*DW +: DW], e.data);
            else n_pass++;
        end
    endtask

    task automatic test_r0();
        exp_t e;
        idle(); wr(0, 0, 64'hFF); iss(0); rd(0, 0, '0, 1'b0, "r0_bypass"); tick();
        n_total++;
        if (busy_vec !== '0) $display("FAIL r0_busy_vec: got %h required 0", busy_vec);
        else n_pass++;
        idle(); wr(1, 0, 64'hFF); rd(1, 0, '0, 1'b0, "r0_read"); rd(2, 0, '0, 1'b0, "r0_read"); tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_total++;
            if (r_data[e.port*DW +: DW] !== e.data || r_busy[e.port] !== e.busy)
                $display("FAIL %s port%0d: got %h/%b required %h/%b", e.name, e.port,
                         r_data[e.port*DW +: DW], r_busy[e.port], e.data, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midcycle();
        exp_t e;
        idle(); wr(0, 3, 64'hAB); iss(4); tick();
        idle(); rd(0, 3, 64'hAB, 1'b0, "pre_reset_read"); rd(1, 4, '0, 1'b1, "pre_reset_busy"); tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_total++;
            if (r_data[e.port*DW +: DW] !== e.data || r_busy[e.port] !== e.busy)
                $display("FAIL %s port%0d: got %h/%b required %h/%b", e.name, e.port,
                         r_data[e.port*DW +: DW], r_busy[e.port], e.data, e.busy);
            else n_pass++;
        end
        idle(); wr(1, 3, 64'h77); iss(3);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (busy_vec !== '0 || r_data !== '0 || r_busy !== '0)
            $display("FAIL midcycle_reset: busy_vec=%h r_busy=%b r_data=%h required all zero",
                     busy_vec, r_busy, r_data);
        else n_pass++;
        tick();
        idle();
        rst_n = 1'b1;
        rd(0, 3, '0, 1'b0, "post_reset_r3"); rd(1, 4, '0, 1'b0, "post_reset_r4");
        rd(2, 3, '0, 1'b0, "post_reset_r3"); tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_total++;
            if (r_data[e.port*DW +: DW] !== e.data || r_busy[e.port] !== e.busy)
                $display("FAIL %s port%0d: got %h/%b required %h/%b", e.name, e.port,
                         r_data[e.port*DW +: DW], r_busy[e.port], e.data, e.busy);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] mregs[64];
        logic          mbusy[64];
        logic [63:0]   mvec;
        logic          wen[NW];
        int            wrn[NW];
        logic [DW-1:0] wd[NW];
        logic          ien;
        int            irn;
        int            rn;
        logic [DW-1:0] ed;
        logic          eb;
        exp_t          e;
        // Model starts from the post-reset state left by the previous test.
        for (int i = 0; i < 64; i++) begin mregs[i] = '0; mbusy[i] = 1'b0; end
        for (int c = 0; c < 300; c++) begin
            idle();
            for (int j = 0; j < NW; j++) begin
                wen[j] = 1'($urandom_range(0, 1));
                wrn[j] = $urandom_range(0, 7);
                wd[j]  = {$urandom, $urandom};
                if (wen[j]) wr(j, wrn[j], wd[j]);
            end
            ien = 1'($urandom_range(0, 1));
            irn = $urandom_range(0, 7);
            if (ien) iss(irn);
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(0, 3) != 0) begin
                    rn = $urandom_range(0, 7);
                    ed = mregs[rn];
                    eb = mbusy[rn];
                    for (int j = 0; j < NW; j++)
                        if (wen[j] && wrn[j] == rn) begin ed = wd[j]; eb = 1'b0; end
                    if (ien && irn == rn) eb = 1'b1;
                    if (rn == 0) begin ed = '0; eb = 1'b0; end
                    rd(k, rn, ed, eb, "random_read");
                end
            end
            for (int j = 0; j < NW; j++)
                if (wen[j] && wrn[j] != 0) begin mregs[wrn[j]] = wd[j]; mbusy[wrn[j]] = 1'b0; end
            if (ien && irn != 0) mbusy[irn] = 1'b1;
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_total++;
                if (r_data[e.port*DW +: DW] !== e.data || r_busy[e.port] !== e.busy)
                    $display("FAIL %s port%0d cyc%0d: got %h/%b required %h/%b", e.name, e.port, c,
                             r_data[e.port*DW +: DW], r_busy[e.port], e.data, e.busy);
                else n_pass++;
            end
            for (int i = 0; i < 64; i++) mvec[i] = mbusy[i];
            n_total++;
            if (busy_vec !== mvec)
                $display("FAIL random_busy_vec cyc%0d: got %h required %h", c, busy_vec, mvec);
            else n_pass++;
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_same_reg_write();
        test_issue_write();
        test_r0();
        test_reset_midcycle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 64, register data width in bits.
REQ-002 Parameter ADDR_W, default 6, register number width; depth is 2**ADDR_W.
REQ-003 Parameter NREAD, default 3, number of read ports, range 1..4.
REQ-004 Parameter NWRITE, default 2, number of write ports, range 1..2.
REQ-005 Port list, one per line (name, direction, width, meaning); clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- r_en  in  NREAD  per-port read enable.
- r_rn  in  NREAD*ADDR_W  packed read register numbers; port k occupies bits [k*ADDR_W +: ADDR_W].
- r_data  out  NREAD*DATA_W  packed registered read data.
- r_busy  out  NREAD  registered scoreboard bit for the register last read on each port.
- w_en  in  NWRITE  per-port write enable.
- w_rn  in  NWRITE*ADDR_W  packed write register numbers.
- w_data  in  NWRITE*DATA_W  packed write data.
- iss_en  in  1  marks register iss_rn as pending, i.e. set busy.
- iss_rn  in  ADDR_W  register being issued.
- busy_vec  out  2**ADDR_W  current scoreboard, bit n is register n.

Function
REQ-006 Register 0 SHALL read as zero, ignore writes, and never be marked busy.
REQ-007 A write with w_en[j]=1 and a nonzero w_rn SHALL update the register at the next rising edge.
REQ-008 If two write ports target the same register in one cycle, the higher-numbered port SHALL win.
REQ-009 Each read port SHALL have 1-cycle latency: with r_en[k]=1, r_data[k] and r_busy[k] SHALL update at the next rising edge.
REQ-010 With r_en[k]=0, r_data[k] and r_busy[k] SHALL hold their previous values.
REQ-011 Reads SHALL be write-first: if a write to the same nonzero register occurs in the read cycle, r_data SHALL return the new write data, using the REQ-008 winner.
REQ-012 A write to register n SHALL clear busy bit n at the same edge as the data update.
REQ-013 iss_en=1 with a nonzero iss_rn SHALL set that busy bit at the next edge.
REQ-014 If an issue and a write hit the same register in one cycle, busy SHALL remain set (issue wins).
REQ-015 r_busy[k] SHALL report the post-edge busy state, i.e. it is consistent with REQ-012 and REQ-014 bypass.
REQ-016 busy_vec SHALL be a direct register output with no combinational path from inputs.
REQ-017 Read ports SHALL be fully independent; any number of ports may read the same register.

Reset
REQ-018 Asserting rst_n low SHALL asynchronously clear all registers, busy_vec, r_data and r_busy to zero.
REQ-019 Reset asserted during an in-flight write or issue SHALL discard that operation.
REQ-020 The first edge after deassertion SHALL behave as a normal cycle.

Structure
REQ-021 The default DATA_W, ADDR_W, NREAD and NWRITE values SHALL be constants in the shared raisin64 CPU package.
REQ-022 The write-resolve and bypass logic SHALL be one sub-module, regfile_wsel, instantiated once per read port.
REQ-023 Parameter values outside the stated ranges SHALL fail elaboration.

Verification
REQ-024 Reset then read r1..r63 on all ports -> all r_data = 0 and busy_vec = 0.
REQ-025 Write port0 r5=0xDEAD_BEEF, then read r5 on port2 next cycle -> r_data[2] = 0xDEADBEEF one cycle later.
REQ-026 Same cycle: port0 writes r7=0x11, port1 writes r7=0x22, port0 reads r7 -> r_data[0] = 0x22, and r7 = 0x22 afterwards.
REQ-027 Issue r9, then issue r9 and write r9=0x5 in the same cycle -> busy_vec[9] stays 1 with data 0x5; a later write clears it to 0.
REQ-028 Write r0=0xFF with iss_rn=0 -> a read of r0 returns 0 and busy_vec[0] = 0.
REQ-029 Pulse rst_n low mid-cycle while w_en=1 for r3 -> r3 reads 0 and all outputs are 0 immediately after assertion.
